// File: rtl/alu_seq.sv
// Sequencer wrapped around an external registered ALU: owns a 4 x 8 register
// file, issues one operation at a time (IDLE -> EXEC -> WB) and commits results/flags.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [1:0] req_rd,
  input  logic [1:0] req_rs,
  input  logic [1:0] req_rt,
  input  logic [2:0] req_shamt,
  input  logic       req_setf,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic [2:0] alu_shamt,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [3:0] flags_q,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic [1:0] dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1. req_ready depends on state only (high in IDLE), so
  // req_valid held outside IDLE is simply not observed.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       do_accept;
  logic       do_wb;
  logic [1:0] rd_q;
  logic       setf_q;
  logic [7:0] rf [4];

  // The ALU leaves its carry position undriven; that bit is never stored.
  logic       alu_c_unused;
  assign alu_c_unused = alu_flags[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    do_accept = 1'b0;
    do_wb     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          do_accept = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = WB;
      WB: begin
        do_wb   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are held from accept through WB so the ALU capture edge sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 3'd0;
      alu_shamt <= 3'd0;
      rd_q      <= 2'd0;
      setf_q    <= 1'b0;
    end else if (do_accept) begin
      alu_a     <= rf[req_rs];
      alu_b     <= rf[req_rt];
      alu_op    <= req_op;
      alu_shamt <= req_shamt;
      rd_q      <= req_rd;
      setf_q    <= req_setf;
    end
  end

  // Writeback is assigned last so it overrides an external load to the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        rf[i] <= 8'h00;
      end
    end else begin
      if (wr_en) begin
        rf[wr_addr] <= wr_data;
      end
      if (do_wb) begin
        rf[rd_q] <= alu_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      flags_q   <= 4'h0;
    end else begin
      rsp_valid <= do_wb;
      if (do_wb) begin
        rsp_data <= alu_out;
        if (setf_q) begin
          flags_q <= {alu_flags[3], alu_flags[2], 1'b0, alu_flags[0]};
        end
      end
    end
  end

  assign dbg_data  = rf[dbg_addr];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a registered stand-in ALU; each task drives
// one scenario and checks it inline against hand-computed values.
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd5;
  localparam logic [2:0] OP_LSL = 3'd6;
  localparam logic [2:0] OP_LSR = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [1:0] req_rd, req_rs, req_rt;
  logic [2:0] req_shamt;
  logic       req_setf;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op, alu_shamt;
  logic [7:0] alu_out = 8'h00;
  logic [3:0] alu_flags = 4'h0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [3:0] flags_q;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  alu_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt),
    .req_shamt(req_shamt), .req_setf(req_setf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flags_q(flags_q),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: V reports the unsigned carry/borrow out; the carry position
  // is driven high on purpose so a sequencer that fails to clear it is caught.
  function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [2:0] sh);
    logic [8:0] w;
    logic [7:0] r;
    logic       v;
    w = 9'd0;
    r = 8'h00;
    v = 1'b0;
    case (op)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; v = w[8]; end
      OP_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; v = w[8]; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_EOR: r = a ^ b;
      OP_NEG: r = 8'h00 - b;
      OP_LSL: r = a << sh;
      OP_LSR: r = a >> sh;
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), r[7], 1'b1, v, r};
  endfunction

  always @(posedge clk) begin
    {alu_flags, alu_out} <= alu_model(alu_op, alu_a, alu_b, alu_shamt);
  end

  task automatic load_reg(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [2:0] sh, input logic setf);
    req_op = op; req_rd = rd; req_rs = rs; req_rt = rt; req_shamt = sh; req_setf = setf;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Handshake (bounded wait on req_ready), then capture rsp_valid after
  // edges T+1, T+2, T+3 in rv[0..2] and rsp_data after T+2.
  task automatic run_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [1:0] rt, input logic [2:0] sh, input logic setf,
                        output logic hs_ok, output logic [2:0] rv, output logic [7:0] data);
    set_req(op, rd, rs, rt, sh, setf);
    req_valid = 1'b1;
    hs_ok = 1'b0;
    for (int i = 0; i < 8 && !hs_ok; i++) begin
      if (req_ready) hs_ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rv = 3'b000;
    data = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rv[k] = rsp_valid;
      if (k == 1) data = rsp_data;
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b0; req_valid = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    dbg_addr = 2'd0;
    set_req(OP_ADD, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({rsp_data, flags_q} !== 12'h000) begin bad++; $display("FAIL reset_data_flags got=%h exp=000", {rsp_data, flags_q}); end
    total++; if ({alu_a, alu_b, alu_op, alu_shamt} !== 22'd0) begin bad++; $display("FAIL reset_alu_ports got=%h exp=0", {alu_a, alu_b, alu_op, alu_shamt}); end
    peek(2'd2, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_rf2 got=%h exp=00", d); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic hs; logic [2:0] rv; logic [7:0] d, r;
    load_reg(2'd1, 8'h05);
    load_reg(2'd2, 8'h03);
    run_op(OP_ADD, 2'd0, 2'd1, 2'd2, 3'd0, 1'b1, hs, rv, d);
    total++; if (hs !== 1'b1) begin bad++; $display("FAIL add_handshake got=%b exp=1", hs); end
    total++; if (rv !== 3'b010) begin bad++; $display("FAIL add_latency got=%b exp=010", rv); end
    total++; if (d !== 8'h08) begin bad++; $display("FAIL add_data got=%h exp=08", d); end
    total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL add_flags got=%b exp=0000", flags_q); end
    peek(2'd0, r);
    total++; if (r !== 8'h08) begin bad++; $display("FAIL add_rf0 got=%h exp=08", r); end
  endtask

  task automatic test_sub;
    logic hs; logic [2:0] rv; logic [7:0] d, r;
    load_reg(2'd1, 8'h03);
    load_reg(2'd2, 8'h05);
    run_op(OP_SUB, 2'd3, 2'd1, 2'd2, 3'd0, 1'b1, hs, rv, d);
    total++; if (d !== 8'hFE) begin bad++; $display("FAIL sub_data got=%h exp=fe", d); end
    total++; if (flags_q !== 4'b0101) begin bad++; $display("FAIL sub_flags got=%b exp=0101", flags_q); end
    peek(2'd3, r);
    total++; if (r !== 8'hFE) begin bad++; $display("FAIL sub_rf3 got=%h exp=fe", r); end
  endtask

  task automatic test_eor_setf;
    logic hs; logic [2:0] rv; logic [7:0] d, r;
    load_reg(2'd1, 8'hAA);
    run_op(OP_EOR, 2'd1, 2'd1, 2'd1, 3'd0, 1'b1, hs, rv, d);
    peek(2'd1, r);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL eor_rf1 got=%h exp=00", r); end
    total++; if (flags_q !== 4'b1000) begin bad++; $display("FAIL eor_flags got=%b exp=1000", flags_q); end
    run_op(OP_ADD, 2'd1, 2'd1, 2'd1, 3'd0, 1'b0, hs, rv, d);
    total++; if ({rv, d} !== {3'b010, 8'h00}) begin bad++; $display("FAIL nosetf_add got=%h exp=%h", {rv, d}, {3'b010, 8'h00}); end
    total++; if (flags_q !== 4'b1000) begin bad++; $display("FAIL nosetf_add_flags got=%b exp=1000", flags_q); end
  endtask

  task automatic test_shift_neg;
    logic hs; logic [2:0] rv; logic [7:0] d;
    load_reg(2'd2, 8'h40);
    run_op(OP_LSL, 2'd0, 2'd2, 2'd3, 3'd1, 1'b0, hs, rv, d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL lsl_data got=%h exp=80", d); end
    total++; if (flags_q !== 4'b1000) begin bad++; $display("FAIL lsl_flags_held got=%b exp=1000", flags_q); end
    run_op(OP_LSR, 2'd1, 2'd0, 2'd3, 3'd7, 1'b0, hs, rv, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL lsr_data got=%h exp=01", d); end
    run_op(OP_NEG, 2'd3, 2'd0, 2'd2, 3'd0, 1'b1, hs, rv, d);
    total++; if (d !== 8'hC0) begin bad++; $display("FAIL neg_data got=%h exp=c0", d); end
    total++; if (flags_q !== 4'b0100) begin bad++; $display("FAIL neg_flags got=%b exp=0100", flags_q); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] rdy;
    logic [7:0] e, r;
    int n_rsp;
    load_reg(2'd0, 8'h01);
    exp_q = {8'h02, 8'h04, 8'h08};
    n_rsp = 0;
    rdy = '0;
    set_req(OP_ADD, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0);
    req_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      rdy[c] = req_ready;
      @(posedge clk); #1;
      if (rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_extra_rsp got=%h exp=none", rsp_data);
        end else begin
          e = exp_q.pop_front();
          total++; if (rsp_data !== e) begin bad++; $display("FAIL b2b_data got=%h exp=%h", rsp_data, e); end
        end
      end
    end
    req_valid = 1'b0;
    total++; if (rdy !== 9'b001001001) begin bad++; $display("FAIL b2b_ready got=%b exp=001001001", rdy); end
    total++; if (n_rsp != 3) begin bad++; $display("FAIL b2b_rsp_count got=%0d exp=3", n_rsp); end
    peek(2'd0, r);
    total++; if (r !== 8'h08) begin bad++; $display("FAIL b2b_rf0 got=%h exp=08", r); end
    total++; if (flags_q !== 4'b0100) begin bad++; $display("FAIL b2b_flags got=%b exp=0100", flags_q); end
  endtask

  task automatic test_wr_collision;
    logic [7:0] r;
    load_reg(2'd1, 8'h10);
    load_reg(2'd2, 8'h20);
    // Load to an operand register at the handshake edge: operands see old value.
    set_req(OP_ADD, 2'd0, 2'd1, 2'd1, 3'd0, 1'b0);
    req_valid = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h55;
    @(posedge clk); #1;
    req_valid = 1'b0; wr_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    total++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h20}) begin bad++; $display("FAIL hs_load_data got=%h exp=%h", {rsp_valid, rsp_data}, {1'b1, 8'h20}); end
    peek(2'd1, r);
    total++; if (r !== 8'h55) begin bad++; $display("FAIL hs_load_rf1 got=%h exp=55", r); end
    // Same-register load at the writeback edge loses.
    set_req(OP_ADD, 2'd2, 2'd1, 2'd2, 3'd0, 1'b0);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h77;
    @(posedge clk); #1;
    wr_en = 1'b0;
    peek(2'd2, r);
    total++; if (r !== 8'h75) begin bad++; $display("FAIL wb_wins_rf2 got=%h exp=75", r); end
    // Different-register load at the writeback edge: both land.
    set_req(OP_ADD, 2'd2, 2'd2, 2'd0, 3'd0, 1'b0);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
    @(posedge clk); #1;
    wr_en = 1'b0;
    peek(2'd2, r);
    total++; if (r !== 8'h95) begin bad++; $display("FAIL both_rf2 got=%h exp=95", r); end
    peek(2'd3, r);
    total++; if (r !== 8'h77) begin bad++; $display("FAIL both_rf3 got=%h exp=77", r); end
  endtask

  task automatic test_reset_exec;
    logic [7:0] r;
    logic [2:0] rv;
    logic [7:0] d;
    int seen;
    load_reg(2'd1, 8'h05);
    set_req(OP_ADD, 2'd0, 2'd1, 2'd1, 3'd3, 1'b1);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rexec_ready got=%b exp=1", req_ready); end
    total++; if ({rsp_valid, rsp_data, flags_q} !== 13'd0) begin bad++; $display("FAIL rexec_outputs got=%h exp=0", {rsp_valid, rsp_data, flags_q}); end
    total++; if ({alu_a, alu_b, alu_op, alu_shamt} !== 22'd0) begin bad++; $display("FAIL rexec_alu_ports got=%h exp=0", {alu_a, alu_b, alu_op, alu_shamt}); end
    for (int a = 0; a < 4; a++) begin
      peek(2'(a), r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL rexec_rf%0d got=%h exp=00", a, r); end
    end
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    @(negedge clk);
    rst = 1'b0;
    set_req(OP_OR, 2'd2, 2'd0, 2'd0, 3'd0, 1'b1);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rexec_first_accept got=%b exp=0", req_ready); end
    rv = 3'b000; d = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rv[k] = rsp_valid;
      if (k == 1) d = rsp_data;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rexec_no_pulse got=%0d exp=0", seen); end
    total++; if ({rv, d} !== {3'b010, 8'h00}) begin bad++; $display("FAIL rexec_new_op got=%h exp=%h", {rv, d}, {3'b010, 8'h00}); end
    total++; if (flags_q !== 4'b1000) begin bad++; $display("FAIL rexec_new_flags got=%b exp=1000", flags_q); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_eor_setf;
    test_shift_neg;
    test_back_to_back;
    test_wr_collision;
    test_reset_exec;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
